// File: rtl/run_length_detector_if.sv
// Sample/control inputs and status outputs of the run-length detector.
interface run_length_detector_if #(
  parameter int unsigned CNT_W = 3,
  parameter int unsigned HIT_W = 8
) ();

  logic             en;
  logic             w;
  logic             clr;
  logic [1:0]       mode;
  logic             z;
  logic             z_pulse;
  logic             run_val;
  logic [CNT_W-1:0] run_cnt;
  logic [HIT_W-1:0] hit_cnt;
  logic [1:0]       state;

  modport master (
    output en, w, clr, mode,
    input  z, z_pulse, run_val, run_cnt, hit_cnt, state
  );

  modport slave (
    input  en, w, clr, mode,
    output z, z_pulse, run_val, run_cnt, hit_cnt, state
  );

endinterface

// File: rtl/run_length_detector.sv
// Tracks runs of identical enabled samples of w and flags runs of at least
// RUN_LEN, with mode-selectable polarity, a match pulse and a saturating hit count.
module run_length_detector #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned HIT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  run_length_detector_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_COUNT = 2'b01;
  localparam logic [1:0] S_MATCH = 2'b10;

  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [HIT_W-1:0] HIT_MAX   = {HIT_W{1'b1}};

  logic [1:0]       state_q,   state_d;
  logic             run_val_q, run_val_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             z_pulse_q, z_pulse_d;
  logic [CNT_W-1:0] cnt_inc;

  // Polarity qualifier: which run values count as a reportable match.
  function automatic logic qual(input logic [1:0] m, input logic v);
    case (m)
      2'b00:   qual = 1'b1;
      2'b01:   qual = ~v;
      2'b10:   qual = v;
      default: qual = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      run_val_q <= 1'b0;
      run_cnt_q <= '0;
      hit_cnt_q <= '0;
      z_pulse_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_val_q <= run_val_d;
      run_cnt_q <= run_cnt_d;
      hit_cnt_q <= hit_cnt_d;
      z_pulse_q <= z_pulse_d;
    end
  end

  assign cnt_inc = run_cnt_q + CNT_ONE;

  // Next state; counting is mode-independent, only pulse/hit are qualified.
  always_comb begin
    state_d   = state_q;
    run_val_d = run_val_q;
    run_cnt_d = run_cnt_q;
    hit_cnt_d = hit_cnt_q;
    z_pulse_d = 1'b0;

    if (bus.clr) begin
      state_d   = S_IDLE;
      run_val_d = 1'b0;
      run_cnt_d = '0;
      hit_cnt_d = '0;
    end else if (bus.en) begin
      case (state_q)
        S_IDLE: begin
          run_val_d = bus.w;
          run_cnt_d = CNT_ONE;
          state_d   = S_COUNT;
        end
        S_COUNT: begin
          if (bus.w == run_val_q) begin
            run_cnt_d = cnt_inc;
            if (cnt_inc == RUN_LEN_C) begin
              state_d = S_MATCH;
              if (qual(bus.mode, bus.w)) begin
                z_pulse_d = 1'b1;
                if (hit_cnt_q != HIT_MAX) hit_cnt_d = hit_cnt_q + HIT_W'(1);
              end
            end
          end else begin
            run_val_d = bus.w;
            run_cnt_d = CNT_ONE;
          end
        end
        S_MATCH: begin
          if (bus.w == run_val_q) begin
            run_cnt_d = RUN_LEN_C;
          end else begin
            run_val_d = bus.w;
            run_cnt_d = CNT_ONE;
            state_d   = S_COUNT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.state   = state_q;
  assign bus.run_val = run_val_q;
  assign bus.run_cnt = run_cnt_q;
  assign bus.hit_cnt = hit_cnt_q;
  assign bus.z_pulse = z_pulse_q;
  assign bus.z       = (state_q == S_MATCH) & qual(bus.mode, run_val_q);

endmodule

// File: doc/run_length_detector.md
Name: run_length_detector

Overview:
- Parametrised successor to the fixed four-in-a-row serial pattern FSM.
- Samples serial input w on qualified clock enables and tracks the current run of identical bits.
- Asserts z while the run length is at least RUN_LEN, with polarity selectable per mode.
- Adds a match pulse, a saturating hit counter and synchronous clear. Sits behind the debouncer, whose output pulse drives en (the debouncer output is not used as a clock).

Parameters:
RUN_LEN, 4, consecutive equal samples required for a match (>=2)
CNT_W, 3, width of run_cnt; must satisfy 2**CNT_W-1 >= RUN_LEN
HIT_W, 8, width of hit_cnt

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  reset, asynchronous, active-high
en  in  1  sample enable; w is sampled only on clk edges with en=1
w  in  1  serial data input
clr  in  1  synchronous clear, active-high
mode  in  2  00 both polarities, 01 zeros only, 10 ones only, 11 detection off
z  out  1  match level
z_pulse  out  1  one-clk pulse on qualified match entry
run_val  out  1  bit value of the current run
run_cnt  out  CNT_W  length of the current run, saturates at RUN_LEN
hit_cnt  out  HIT_W  number of qualified match entries, saturating
state  out  2  FSM state: 00 IDLE, 01 COUNT, 10 MATCH

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE; run_cnt=0, run_val=0, hit_cnt=0, z_pulse=0; z=0.
- clr=1 at a clk edge: same values as reset. clr has priority over en.
- en=0 at a clk edge: all registers hold, except z_pulse, which is cleared.
- Edges with en=1 and clr=0 follow the transitions below.
- IDLE: run_val<=w, run_cnt<=1, go to COUNT.
- COUNT, w==run_val: run_cnt<=run_cnt+1. If run_cnt+1==RUN_LEN, go to MATCH; otherwise stay in COUNT.
- COUNT, w!=run_val: run_val<=w, run_cnt<=1, stay in COUNT.
- MATCH, w==run_val: stay in MATCH; run_cnt holds at RUN_LEN.
- MATCH, w!=run_val: run_val<=w, run_cnt<=1, go to COUNT. Entering the opposite polarity restarts counting from 1.
- qual(v): true when mode=00; mode=01 and v=0; or mode=10 and v=1. False when mode=11.
- z: combinational, z = (state==MATCH) & qual(run_val). A mode change affects z immediately. Counting and FSM state are independent of mode.
- z_pulse: registered. It is 1 for exactly one clk cycle after the edge that moves COUNT->MATCH, when qual(w) holds at that edge. Remaining in MATCH never re-pulses.
- hit_cnt: increments on the same edge that sets z_pulse; saturates at 2**HIT_W-1 (no wrap).
- Latency: z rises in the clk cycle after the RUN_LEN-th consecutive equal enabled sample. A single differing sample drops z in the cycle after that edge.
- en is a single-cycle strobe from the debouncer. Holding en=1 for several clocks samples w on every one of those clocks.
- Illegal state encoding 11: the next enabled edge goes to IDLE; z=0 while in it.

Test Plan:
- Reset: assert rst mid-cycle with no clk edge -> outputs immediately state=00, run_cnt=0, hit_cnt=0, z=0, z_pulse=0.
- Zeros run: RUN_LEN=4, mode=00, five en strobes with w=0 -> run_cnt 1,2,3,4,4; state 01,01,01,10,10; z=1 after 4th strobe; z_pulse high one clk only; hit_cnt=1.
- Polarity switch: continuing from the zeros run, four en strobes with w=1 -> run_cnt 1,2,3,4; z=0 after 1st strobe, z=1 after 4th; hit_cnt=2. A single w=0 strobe afterwards -> run_cnt=1, run_val=0, z=0.
- Mode filter: mode=01, four en strobes with w=1 -> state=10, z=0, no z_pulse, hit_cnt unchanged. Switching mode to 10 -> z=1 in the same cycle, still no pulse.
- Enable gating: toggle w every clk with en=0 for 10 clks -> no register changes. Then clr=1 together with en=1 -> state=00, hit_cnt=0.
- Saturation: HIT_W=2; produce 5 qualified match entries (alternating 4-zero and 4-one runs) -> hit_cnt 1,2,3,3,3; z_pulse still fires on all five.
